// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared state, opcode and datapath-select encodings for the multicycle controller
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUB_REGB    = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// rtl/mc_output_decode.sv - per-state datapath strobes, with memory-handshake strobes qualified by mem_ready
module mc_output_decode
    import mc_ctrl_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = ALUB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // IR and PC only advance on the cycle the fetch actually lands
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = ALUB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.i_or_d     = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUB_REGB;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = ALUB_REGB;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-style control FSM: state register, next-state logic, reset gating
module multicycle_control
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    state_e state_q;
    state_e state_d;
    ctrl_t  dec_ctrl;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:    state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WR:    state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    mc_output_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (dec_ctrl)
    );

    // Outputs are held quiet during reset so no write can escape mid-wait
    assign ctrl = reset ? '0 : dec_ctrl;

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign instr_done    = ctrl.instr_done;
    assign illegal_op    = !reset && (state_q == S_DECODE) && !is_legal_op(opcode);
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed and random self-checking bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic [17:0] ctl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .instr_done(instr_done),
        .illegal_op(illegal_op)
    );

    // pc_write pwc iord mrd mwr irw m2r rdst rwr asa | asb | aluop | pcsrc | done ill
    assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, instr_done, illegal_op};

    localparam logic [17:0] C_ZERO    = 18'b0;
    localparam logic [17:0] C_FETCH_R = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] C_FETCH_W = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] C_DECODE  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] C_ILLEGAL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
    localparam logic [17:0] C_ADDR    = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] C_MEMRD   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] C_MEMWB   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
    localparam logic [17:0] C_MEMWR_W = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] C_MEMWR_R = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
    localparam logic [17:0] C_REXEC   = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [17:0] C_RWB     = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
    localparam logic [17:0] C_ADDIWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
    localparam logic [17:0] C_BRANCH  = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [17:0] C_JUMP    = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] c;
    } step_t;

    step_t seq[$];

    function automatic step_t mk(input logic r, input logic [5:0] o, input logic y,
                                 input logic [3:0] s, input logic [17:0] c);
        step_t t;
        t.rst = r; t.op = o; t.rdy = y; t.st = s; t.c = c;
        return t;
    endfunction

    function automatic logic legal(input logic [5:0] op);
        return op == 6'h00 || op == 6'h23 || op == 6'h2b || op == 6'h04 ||
               op == 6'h02 || op == 6'h08;
    endfunction

    function automatic logic [3:0] model_next(input logic [3:0] s, input logic [5:0] op,
                                              input logic rdy);
        case (s)
            4'd0: return rdy ? 4'd1 : 4'd0;
            4'd1: begin
                if (op == 6'h00) return 4'd6;
                if (op == 6'h23 || op == 6'h2b) return 4'd2;
                if (op == 6'h04) return 4'd8;
                if (op == 6'h02) return 4'd9;
                if (op == 6'h08) return 4'd10;
                return 4'd0;
            end
            4'd2:  return (op == 6'h23) ? 4'd3 : 4'd5;
            4'd3:  return rdy ? 4'd4 : 4'd3;
            4'd5:  return rdy ? 4'd0 : 4'd5;
            4'd6:  return 4'd7;
            4'd10: return 4'd11;
            default: return 4'd0;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        seq.push_back(mk(1, 6'h23, 1, 4'd0, C_ZERO));
        seq.push_back(mk(0, 6'h23, 1, 4'd0, C_FETCH_R));
        seq.push_back(mk(0, 6'h23, 1, 4'd1, C_DECODE));
        seq.push_back(mk(0, 6'h23, 1, 4'd2, C_ADDR));
        seq.push_back(mk(0, 6'h23, 0, 4'd3, C_MEMRD));
        seq.push_back(mk(1, 6'h23, 0, 4'd3, C_ZERO));
        seq.push_back(mk(1, 6'h23, 1, 4'd0, C_ZERO));
        seq.push_back(mk(1, 6'h23, 1, 4'd0, C_ZERO));
        seq.push_back(mk(0, 6'h23, 0, 4'd0, C_FETCH_W));
        foreach (seq[k]) begin
            reset = seq[k].rst; opcode = seq[k].op; mem_ready = seq[k].rdy;
            #1;
            checks += 2;
            if (state !== seq[k].st) begin
                errors++;
                $display("FAIL reset step %0d state: got %0d expected %0d", k, state, seq[k].st);
            end
            if (ctl !== seq[k].c) begin
                errors++;
                $display("FAIL reset step %0d ctl: got %b expected %b", k, ctl, seq[k].c);
            end
            tick();
        end
        seq.delete();
    endtask

    task automatic test_rtype;
        seq.push_back(mk(0, 6'h00, 1, 4'd0, C_FETCH_R));
        seq.push_back(mk(0, 6'h00, 1, 4'd1, C_DECODE));
        seq.push_back(mk(0, 6'h00, 1, 4'd6, C_REXEC));
        seq.push_back(mk(0, 6'h00, 1, 4'd7, C_RWB));
        foreach (seq[k]) begin
            reset = seq[k].rst; opcode = seq[k].op; mem_ready = seq[k].rdy;
            #1;
            checks += 2;
            if (state !== seq[k].st) begin
                errors++;
                $display("FAIL rtype step %0d state: got %0d expected %0d", k, state, seq[k].st);
            end
            if (ctl !== seq[k].c) begin
                errors++;
                $display("FAIL rtype step %0d ctl: got %b expected %b", k, ctl, seq[k].c);
            end
            tick();
        end
        seq.delete();
    endtask

    task automatic test_lw_wait;
        seq.push_back(mk(0, 6'h23, 1, 4'd0, C_FETCH_R));
        seq.push_back(mk(0, 6'h23, 1, 4'd1, C_DECODE));
        seq.push_back(mk(0, 6'h23, 1, 4'd2, C_ADDR));
        seq.push_back(mk(0, 6'h23, 0, 4'd3, C_MEMRD));
        seq.push_back(mk(0, 6'h23, 0, 4'd3, C_MEMRD));
        seq.push_back(mk(0, 6'h23, 1, 4'd3, C_MEMRD));
        seq.push_back(mk(0, 6'h23, 1, 4'd4, C_MEMWB));
        seq.push_back(mk(0, 6'h2b, 0, 4'd0, C_FETCH_W));
        foreach (seq[k]) begin
            reset = seq[k].rst; opcode = seq[k].op; mem_ready = seq[k].rdy;
            #1;
            checks += 2;
            if (state !== seq[k].st) begin
                errors++;
                $display("FAIL lw_wait step %0d state: got %0d expected %0d", k, state, seq[k].st);
            end
            if (ctl !== seq[k].c) begin
                errors++;
                $display("FAIL lw_wait step %0d ctl: got %b expected %b", k, ctl, seq[k].c);
            end
            tick();
        end
        seq.delete();
    endtask

    task automatic test_sw_addi;
        seq.push_back(mk(0, 6'h2b, 1, 4'd0, C_FETCH_R));
        seq.push_back(mk(0, 6'h2b, 1, 4'd1, C_DECODE));
        seq.push_back(mk(0, 6'h2b, 1, 4'd2, C_ADDR));
        seq.push_back(mk(0, 6'h2b, 0, 4'd5, C_MEMWR_W));
        seq.push_back(mk(0, 6'h2b, 1, 4'd5, C_MEMWR_R));
        seq.push_back(mk(0, 6'h08, 1, 4'd0, C_FETCH_R));
        seq.push_back(mk(0, 6'h08, 1, 4'd1, C_DECODE));
        seq.push_back(mk(0, 6'h08, 1, 4'd10, C_ADDR));
        seq.push_back(mk(0, 6'h08, 1, 4'd11, C_ADDIWB));
        foreach (seq[k]) begin
            reset = seq[k].rst; opcode = seq[k].op; mem_ready = seq[k].rdy;
            #1;
            checks += 2;
            if (state !== seq[k].st) begin
                errors++;
                $display("FAIL sw_addi step %0d state: got %0d expected %0d", k, state, seq[k].st);
            end
            if (ctl !== seq[k].c) begin
                errors++;
                $display("FAIL sw_addi step %0d ctl: got %b expected %b", k, ctl, seq[k].c);
            end
            tick();
        end
        seq.delete();
    endtask

    task automatic test_back_to_back;
        seq.push_back(mk(0, 6'h04, 1, 4'd0, C_FETCH_R));
        seq.push_back(mk(0, 6'h04, 1, 4'd1, C_DECODE));
        seq.push_back(mk(0, 6'h04, 1, 4'd8, C_BRANCH));
        seq.push_back(mk(0, 6'h02, 1, 4'd0, C_FETCH_R));
        seq.push_back(mk(0, 6'h02, 1, 4'd1, C_DECODE));
        seq.push_back(mk(0, 6'h02, 1, 4'd9, C_JUMP));
        foreach (seq[k]) begin
            reset = seq[k].rst; opcode = seq[k].op; mem_ready = seq[k].rdy;
            #1;
            checks += 2;
            if (state !== seq[k].st) begin
                errors++;
                $display("FAIL back_to_back step %0d state: got %0d expected %0d", k, state, seq[k].st);
            end
            if (ctl !== seq[k].c) begin
                errors++;
                $display("FAIL back_to_back step %0d ctl: got %b expected %b", k, ctl, seq[k].c);
            end
            tick();
        end
        seq.delete();
    endtask

    task automatic test_illegal;
        seq.push_back(mk(0, 6'h3f, 1, 4'd0, C_FETCH_R));
        seq.push_back(mk(0, 6'h3f, 1, 4'd1, C_ILLEGAL));
        seq.push_back(mk(0, 6'h01, 1, 4'd0, C_FETCH_R));
        seq.push_back(mk(0, 6'h01, 1, 4'd1, C_ILLEGAL));
        seq.push_back(mk(0, 6'h01, 0, 4'd0, C_FETCH_W));
        foreach (seq[k]) begin
            reset = seq[k].rst; opcode = seq[k].op; mem_ready = seq[k].rdy;
            #1;
            checks += 2;
            if (state !== seq[k].st) begin
                errors++;
                $display("FAIL illegal step %0d state: got %0d expected %0d", k, state, seq[k].st);
            end
            if (ctl !== seq[k].c) begin
                errors++;
                $display("FAIL illegal step %0d ctl: got %b expected %b", k, ctl, seq[k].c);
            end
            tick();
        end
        seq.delete();
    endtask

    task automatic test_random;
        logic [5:0] legal_ops [6];
        logic [3:0] exp_s;
        int         done_cnt;
        int         legal_cnt;
        legal_ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08};
        exp_s     = 4'd0;
        done_cnt  = 0;
        legal_cnt = 0;
        reset     = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (exp_s == 4'd0) begin
                if ($urandom_range(0, 9) < 8) opcode = legal_ops[$urandom_range(0, 5)];
                else opcode = 6'($urandom_range(0, 63));
            end
            mem_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks += 2;
            if (state !== exp_s) begin
                errors++;
                $display("FAIL random cycle %0d state: got %0d expected %0d", i, state, exp_s);
            end
            if ((mem_read & mem_write) !== 1'b0) begin
                errors++;
                $display("FAIL random cycle %0d rd_wr_overlap: got %b%b expected not both 1",
                         i, mem_read, mem_write);
            end
            if (instr_done === 1'b1) done_cnt++;
            if (exp_s == 4'd1 && legal(opcode)) legal_cnt++;
            exp_s = model_next(exp_s, opcode, mem_ready);
            tick();
        end
        // let any in-flight instruction retire before comparing counts
        for (int i = 0; i < 40 && exp_s != 4'd0; i++) begin
            mem_ready = 1'b1;
            #1;
            if (instr_done === 1'b1) done_cnt++;
            exp_s = model_next(exp_s, opcode, mem_ready);
            tick();
        end
        checks++;
        if (done_cnt !== legal_cnt) begin
            errors++;
            $display("FAIL random done_count: got %0d expected %0d", done_cnt, legal_cnt);
        end
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 6'h00;
        mem_ready = 1'b0;
        tick();
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_addi();
        test_back_to_back();
        test_illegal();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-002 Inputs SHALL be: opcode  input  6  IR[31:26], stable from DECODE onward; mem_ready  input  1  memory access completes this cycle.
REQ-003 Datapath strobes SHALL be: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each.
REQ-004 Multi-bit controls SHALL be: alu_src_b  output  2  (00 regB, 01 const 4, 10 sext imm, 11 sext imm<<2); alu_op  output  2  (00 add, 01 sub, 10 funct); pc_source  output  2  (00 ALU result, 01 ALUOut, 10 jump target).
REQ-005 Status outputs SHALL be: state  output  4  current state encoding; instr_done  output  1  retire pulse; illegal_op  output  1  unsupported opcode pulse.

Function
REQ-006 The block SHALL be a Moore FSM with registered state; all outputs are combinational from state, except the mem_ready-qualified strobes named below.
REQ-007 States SHALL be FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB.
REQ-008 Any output not listed for a state SHALL be 0.
REQ-009 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-010 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; opcode 000000->R_EXEC, 100011/101011->MEM_ADDR, 000100->BRANCH, 000010->JUMP, 001000->ADDI_EXEC.
REQ-011 DECODE with any other opcode: illegal_op=1 for that cycle, next state FETCH, no write strobe asserted.
REQ-012 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; lw->MEM_RD, sw->MEM_WR.
REQ-013 MEM_RD: mem_read=1, i_or_d=1; stay while mem_ready=0, else ->MEM_WB.
REQ-014 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1; ->FETCH.
REQ-015 MEM_WR: mem_write=1, i_or_d=1; stay while mem_ready=0; on mem_ready=1 instr_done=1, ->FETCH.
REQ-016 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 ->R_WB; R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 ->FETCH.
REQ-017 ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 ->ADDI_WB; ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 ->FETCH.
REQ-018 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1 ->FETCH.
REQ-019 JUMP: pc_write=1, pc_source=10, instr_done=1 ->FETCH.
REQ-020 Latency with mem_ready held 1 SHALL be: beq/j 3 cycles; R-type/addi/sw 4 cycles; lw 5 cycles; each mem_ready=0 cycle adds one.
REQ-021 instr_done SHALL be exactly one cycle per retired instruction; illegal opcodes SHALL NOT assert instr_done.
REQ-022 mem_read and mem_write SHALL never be asserted in the same cycle.

Reset
REQ-023 While reset=1 at a rising edge, state SHALL become FETCH regardless of current state, including mid-wait in MEM_RD/MEM_WR.
REQ-024 While reset=1, all outputs except state SHALL be forced to 0; no write strobe may leak during reset.
REQ-025 On the first edge after reset deasserts, the FSM SHALL evaluate FETCH normally.

Structure
REQ-026 Opcode constants, state encoding, and alu_op/alu_src_b/pc_source encodings SHALL reside in a shared package, mc_ctrl_pkg.
REQ-027 The output decode SHALL be one combinational sub-module, mc_output_decode (state, mem_ready -> strobes); next-state logic and the state register stay in multicycle_control.

Verification
REQ-028 Reset held 3 cycles during MEM_RD, then released -> state=FETCH, no reg_write/mem_write seen; mem_read=1 from the first post-reset cycle.
REQ-029 opcode=000000, mem_ready=1 -> states FETCH,DECODE,R_EXEC,R_WB; instr_done on cycle 4 only; alu_op=10 in R_EXEC.
REQ-030 opcode=100011, mem_ready low 2 cycles in MEM_RD -> MEM_RD lasts 3 cycles; total 7 cycles; reg_write=mem_to_reg=1 in MEM_WB only.
REQ-031 opcode=000100 then 000010 back-to-back -> each takes 3 cycles; pc_write_cond=1/pc_source=01 in BRANCH, pc_write=1/pc_source=10 in JUMP.
REQ-032 opcode=111111 -> illegal_op=1 in DECODE for one cycle, next state FETCH, instr_done never asserted.
REQ-033 Random opcode/mem_ready stream of 10k cycles -> mem_read&mem_write never both 1; instr_done count equals number of legal decodes.
